// File: rtl/sbq_sequencer_if.sv
// sbq_sequencer_if: sensor/counter-side bundle between the queue sequencer and its environment
// master: drives sensors, n_tellers, p_count; observes requests, rejects, busy, wait_time
// slave : the sequencer itself
interface sbq_sequencer_if #(parameter int N = 3);
    logic         front_sensor;
    logic         back_sensor;
    logic [1:0]   n_tellers;
    logic [N-1:0] p_count;
    logic         mode1;
    logic         mode2;
    logic         enter_reject;
    logic         leave_reject;
    logic         event_lost;
    logic         busy;
    logic [7:0]   wait_time;

    modport master (
        output front_sensor, back_sensor, n_tellers, p_count,
        input  mode1, mode2, enter_reject, leave_reject, event_lost, busy, wait_time
    );

    modport slave (
        input  front_sensor, back_sensor, n_tellers, p_count,
        output mode1, mode2, enter_reject, leave_reject, event_lost, busy, wait_time
    );
endinterface

// File: rtl/sbq_sequencer.sv
// sbq_sequencer: debounces entry/exit photocells and issues arbitrated inc/dec requests to the people counter
// clk   : system clock, rising edge
// reset : asynchronous, active-low
// bus   : sensors, n_tellers, p_count in; mode1/mode2, rejects, event_lost, busy, wait_time out (all registered)
module sbq_sequencer #(
    parameter int N            = 3,
    parameter int DEBOUNCE     = 4,
    parameter int SERVICE_TIME = 3
) (
    input logic            clk,
    input logic            reset,
    sbq_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE_ENTER, ISSUE_LEAVE, SETTLE} state_t;

    state_t     state;
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [3:0] cnt [2];
    logic [1:0] fall;
    logic [1:0] pend;
    logic [1:0] clr;
    logic       leave_next;
    logic       grant_enter;
    logic       grant_leave;
    logic       full;
    logic       empty;
    logic [1:0] t;
    logic [7:0] wait_n;

    // bit 0 = front (enter), bit 1 = back (leave)
    assign raw = {bus.back_sensor, bus.front_sensor};

    // a completed pass is the debounced level dropping on this very edge
    always_comb begin
        fall = '0;
        for (int i = 0; i < 2; i++)
            fall[i] = deb[i] & ~sync2[i] & (cnt[i] == 4'(DEBOUNCE - 1));
    end

    assign grant_enter = pend[0] & (~pend[1] | ~leave_next);
    assign grant_leave = pend[1] & ~grant_enter;
    assign clr         = (state == IDLE) ? {grant_leave, grant_enter} : 2'b00;
    assign full        = bus.p_count == {N{1'b1}};
    assign empty       = bus.p_count == '0;
    assign t           = (bus.n_tellers == 2'd0) ? 2'd1 : bus.n_tellers;
    assign wait_n      = empty ? 8'd0 : 8'((8'(bus.p_count) + 8'(t) - 8'd1) * 8'(SERVICE_TIME));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            sync1            <= '0;
            sync2            <= '0;
            deb              <= '0;
            cnt[0]           <= '0;
            cnt[1]           <= '0;
            pend             <= '0;
            leave_next       <= 1'b0;
            bus.mode1        <= 1'b0;
            bus.mode2        <= 1'b0;
            bus.enter_reject <= 1'b0;
            bus.leave_reject <= 1'b0;
            bus.event_lost   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.wait_time    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == 4'(DEBOUNCE - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            // an event landing on an already-set pending bit is dropped
            pend             <= (pend & ~clr) | (fall & ~pend);
            bus.event_lost   <= |(fall & pend);
            bus.wait_time    <= wait_n;
            bus.mode1        <= 1'b0;
            bus.mode2        <= 1'b0;
            bus.enter_reject <= 1'b0;
            bus.leave_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_enter) begin
                        if (full) begin
                            bus.enter_reject <= 1'b1;
                        end else begin
                            state      <= ISSUE_ENTER;
                            bus.mode1  <= 1'b1;
                            bus.busy   <= 1'b1;
                            leave_next <= 1'b1;
                        end
                    end else if (grant_leave) begin
                        if (empty) begin
                            bus.leave_reject <= 1'b1;
                        end else begin
                            state      <= ISSUE_LEAVE;
                            bus.mode2  <= 1'b1;
                            bus.busy   <= 1'b1;
                            leave_next <= 1'b0;
                        end
                    end
                end
                ISSUE_ENTER, ISSUE_LEAVE: state <= SETTLE;
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbq_sequencer.sv
// tb_sbq_sequencer: directed self-checking bench for sbq_sequencer (N=3, DEBOUNCE=4, SERVICE_TIME=3)
module tb_sbq_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int passed = 0;
    int total  = 0;
    int cyc, n_m1, n_m2, n_er, n_lr, n_lost, n_busy, f_m1, f_m2, l_m2, f_er, f_lr;

    sbq_sequencer_if #(.N(3)) bus ();

    sbq_sequencer #(.N(3), .DEBOUNCE(4), .SERVICE_TIME(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr();
        cyc = 0; n_m1 = 0; n_m2 = 0; n_er = 0; n_lr = 0; n_lost = 0; n_busy = 0;
        f_m1 = 0; f_m2 = 0; l_m2 = 0; f_er = 0; f_lr = 0;
    endtask

    // one clock; the model counter applies a request seen in the previous cycle
    task automatic tick();
        logic m1, m2;
        m1 = bus.mode1;
        m2 = bus.mode2;
        @(posedge clk);
        #1;
        if (m1) bus.p_count = bus.p_count + 3'd1;
        if (m2) bus.p_count = bus.p_count - 3'd1;
        cyc++;
        if (bus.mode1) begin n_m1++; if (f_m1 == 0) f_m1 = cyc; end
        if (bus.mode2) begin n_m2++; if (f_m2 == 0) f_m2 = cyc; l_m2 = cyc; end
        if (bus.enter_reject) begin n_er++; if (f_er == 0) f_er = cyc; end
        if (bus.leave_reject) begin n_lr++; if (f_lr == 0) f_lr = cyc; end
        if (bus.event_lost) n_lost++;
        if (bus.busy) n_busy++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // hold the chosen sensors broken for 10 cycles, then release; cycle count restarts at the fall
    task automatic pass(input logic f, input logic b);
        bus.front_sensor = f;
        bus.back_sensor  = b;
        run(10);
        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        clr();
    endtask

    initial begin
        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        bus.n_tellers    = 2'd1;
        bus.p_count      = 3'd5;
        clr();
        for (int i = 0; i < 6; i++) begin
            bus.front_sensor = i[0];
            bus.back_sensor  = ~i[0];
            tick();
        end
        chk("rst_pulses", n_m1 + n_m2 + n_er + n_lr + n_lost, 0);
        chk("rst_busy", n_busy, 0);
        chk("rst_wait", int'(bus.wait_time), 0);
        bus.front_sensor = 1'b0;
        bus.back_sensor  = 1'b0;
        bus.p_count      = 3'd0;
        tick();
        reset = 1'b1;
        clr();
        run(10);
        chk("rel_wait", int'(bus.wait_time), 0);
        chk("rel_idle", n_busy + n_m1 + n_m2 + n_er + n_lr + n_lost, 0);

        bus.p_count = 3'd2;
        pass(1'b1, 1'b0);
        run(12);
        chk("entry_count", n_m1, 1);
        chk("entry_latency", f_m1, 7);
        chk("entry_no_dec", n_m2, 0);
        chk("entry_busy_cycles", n_busy, 2);
        chk("entry_wait", int'(bus.wait_time), 9);

        clr();
        bus.front_sensor = 1'b1;
        run(3);
        bus.front_sensor = 1'b0;
        run(15);
        chk("glitch_events", n_m1 + n_er + n_lost, 0);
        chk("glitch_busy", n_busy, 0);

        pass(1'b1, 1'b1);
        run(16);
        chk("sim1_leave_first", f_m2, 7);
        chk("sim1_enter_second", f_m1, 10);
        chk("sim1_counts", n_m1 * 10 + n_m2, 11);

        pass(1'b0, 1'b1);
        run(10);
        chk("back_single", f_m2, 7);
        bus.p_count = 3'd3;

        pass(1'b1, 1'b1);
        run(16);
        chk("sim2_enter_first", f_m1, 7);
        chk("sim2_leave_second", f_m2, 10);
        chk("sim2_counts", n_m1 * 10 + n_m2, 11);

        bus.p_count = 3'd7;
        pass(1'b1, 1'b0);
        run(12);
        chk("full_reject", n_er, 1);
        chk("full_reject_time", f_er, 7);
        chk("full_no_inc", n_m1, 0);
        chk("full_busy", n_busy, 0);
        chk("full_wait", int'(bus.wait_time), 21);

        bus.p_count = 3'd0;
        pass(1'b0, 1'b1);
        run(12);
        chk("empty_reject", n_lr, 1);
        chk("empty_reject_time", f_lr, 7);
        chk("empty_no_dec", n_m2, 0);
        chk("empty_wait", int'(bus.wait_time), 0);

        bus.n_tellers = 2'd0;
        bus.p_count   = 3'd1;
        run(2);
        chk("wait_t0_p1", int'(bus.wait_time), 3);
        bus.n_tellers = 2'd3;
        run(2);
        chk("wait_t3_p1", int'(bus.wait_time), 9);
        bus.n_tellers = 2'd2;
        bus.p_count   = 3'd5;
        run(2);
        chk("wait_t2_p5", int'(bus.wait_time), 18);
        bus.n_tellers = 2'd1;

        bus.p_count = 3'd3;
        pass(1'b1, 1'b1);
        run(4);
        bus.back_sensor = 1'b1;
        run(4);
        bus.back_sensor = 1'b0;
        run(14);
        chk("ovr_enter", f_m1, 7);
        chk("ovr_leave1", f_m2, 10);
        chk("ovr_leave2", l_m2, 15);
        chk("ovr_leave_count", n_m2, 2);
        chk("ovr_no_lost", n_lost, 0);
        chk("ovr_model_count", int'(bus.p_count), 2);

        bus.p_count = 3'd3;
        pass(1'b1, 1'b0);
        run(7);
        chk("abort_pre_mode1", int'(bus.mode1), 1);
        reset = 1'b0;
        #1;
        chk("abort_mode1_cut", int'(bus.mode1), 0);
        chk("abort_busy_cut", int'(bus.busy), 0);
        run(3);
        reset = 1'b1;
        clr();
        run(15);
        chk("abort_no_more", n_m1 + n_m2 + n_er + n_lr, 0);
        chk("abort_idle", n_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sbq_sequencer.md
# sbq_sequencer

Front-end controller for the single-bank queue people counter. It conditions the raw entry and exit photocell sensors and turns each completed pass into exactly one increment or decrement request to the counter. Simultaneous requests are arbitrated, and requests the counter cannot honour (enter when full, leave when empty) are blocked. It also publishes a registered estimated-wait-time value for the display.

## Interface
- N, 3, counter width; queue capacity is 2**N-1.
- DEBOUNCE, 4, consecutive identical synchronized samples required to accept a sensor level change (2..15).
- SERVICE_TIME, 3, time units per customer per teller slot (1..15).

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- front_sensor  in  1  entry photocell, 1 = beam broken; asynchronous to clk.
- back_sensor  in  1  exit photocell, 1 = beam broken; asynchronous to clk.
- n_tellers  in  2  active tellers; 0 is treated as 1.
- p_count  in  N  current counter value.
- mode1  out  1  increment request to counter (one-cycle pulse).
- mode2  out  1  decrement request to counter (one-cycle pulse).
- enter_reject  out  1  one-cycle pulse: entry event dropped, queue full.
- leave_reject  out  1  one-cycle pulse: exit event dropped, queue empty.
- event_lost  out  1  one-cycle pulse: new event on a sensor whose previous event is still pending.
- busy  out  1  FSM not in IDLE.
- wait_time  out  8  estimated wait.

## Operation
- Each sensor goes through a 2-flop synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE consecutive synchronized samples differ from it.
- An event is a debounced 1->0 transition (person has fully passed). A front event sets enter_pend. A back event sets leave_pend.
- If a pending bit is already set when its event arrives, the event is discarded and event_lost pulses.
- full = (p_count == 2**N-1); empty = (p_count == 0). Both are computed from p_count directly; the counter's registered flags are not used.
- FSM states and transitions:
  - IDLE
    - Neither pending: stay.
    - One pending: grant it.
    - Both pending: grant the side not granted last (round-robin; after reset, enter is granted first).
    - Granted enter while full: clear enter_pend, pulse enter_reject, stay IDLE.
    - Granted leave while empty: clear leave_pend, pulse leave_reject, stay IDLE.
    - Otherwise: clear the granted pending bit, record the grant, go to ISSUE_ENTER or ISSUE_LEAVE.
  - ISSUE_ENTER: mode1=1, mode2=0 for this cycle; next state SETTLE.
  - ISSUE_LEAVE: mode1=0, mode2=1 for this cycle; next state SETTLE.
  - SETTLE: one cycle so p_count reflects the update; next state IDLE.
- mode1 and mode2 are never both 1. All outputs are registered.
- wait_time
  - Recomputed every cycle, in 8 bits, as (p_count + T - 1) * SERVICE_TIME when p_count != 0, where T = max(n_tellers, 1).
  - Equals 0 when p_count == 0.
  - Worst case, (7+3-1)*15 = 135, fits in 8 bits; no saturation logic is needed.

## Timing
- Reset (reset low): all outputs 0. FSM goes to IDLE, pending bits clear, debounced levels = 0, debounce counters = 0, round-robin pointer = "enter next".
- Assertion mid-transaction aborts it immediately; a mode pulse in flight is cut.
- Sensor latency: a raw 1->0 change sets the pending bit 2 + DEBOUNCE cycles later, provided the input is stable.
- Request latency:
  - Pending set at edge k: FSM in ISSUE at edge k+1 with the mode pulse high for exactly one cycle; counter updates at edge k+2; SETTLE until edge k+3.
  - Throughput: one counter update per 3 cycles.
- Reject path: the reject pulse is high for the cycle after the edge where IDLE evaluates the grant; there is no counter pulse.
- An event arriving during ISSUE/SETTLE is held in its pending bit and serviced on return to IDLE.
- wait_time lags p_count by one cycle.

## Test plan
- Reset hold: reset low with sensors toggling -> all outputs 0, busy 0. Release with p_count=0 -> wait_time stays 0.
- Single entry: front_sensor 0->1 for 10 cycles then 0, p_count=2, n_tellers=1 -> exactly one mode1 pulse 2+DEBOUNCE+1 cycles after the fall. After the model counter reaches 3, wait_time = 9.
- Glitch rejection: front_sensor high for 3 cycles (DEBOUNCE=4) -> no event, no mode1 pulse.
- Simultaneous events: both sensors fall in the same cycle, p_count=3 -> mode1 pulse first, then mode2 pulse 3 cycles later. Repeat -> leave first, then enter, per the round-robin pointer.
- Boundaries:
  - p_count=7, front event -> enter_reject pulse, no mode1.
  - p_count=0, back event -> leave_reject pulse, no mode2.
  - n_tellers=0, p_count=1 -> wait_time = 3.
- Overrun and abort:
  - Two back events while the FSM is busy -> first is serviced; second pulses event_lost only if leave_pend is still set.
  - reset low during ISSUE_ENTER -> mode1 drops immediately and no further pulse follows.
